// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared constants for the round-robin N:1 mux
package rr_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int N_MIN = 2;
  localparam int N_MAX = 16;

  // Channel-index width; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - rotating-priority grant search starting at ptr_i
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = idx_width(N)
) (
  input  logic [SW-1:0] ptr_i,
  input  logic [N-1:0]  req_i,
  output logic [SW-1:0] gnt_idx_o,
  output logic          gnt_valid_o
);

  logic [SW:0]   sum;
  logic [SW-1:0] cand;

  always_comb begin
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    sum         = '0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
      // ptr_i is always below N, so one conditional subtract performs the wrap.
      sum = {1'b0, ptr_i} + (SW+1)'(k);
      if (sum >= (SW+1)'(N)) begin
        sum = sum - (SW+1)'(N);
      end
      cand = sum[SW-1:0];
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_nx1.sv
// rtl/rr_mux_nx1.sv - N:1 stream mux with fixed or round-robin selection
module rr_mux_nx1
  import rr_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = idx_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [SW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] ch_q, ch_d;
  logic          valid_q, valid_d;

  logic [SW-1:0] rr_idx;
  logic          rr_valid;
  logic          fix_valid;
  logic [SW-1:0] gnt_idx;
  logic          gnt_valid;
  logic          can_load;
  logic          xfer;
  logic [W-1:0]  gnt_data;

  rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .ptr_i       (ptr_q),
    .req_i       (in_valid),
    .gnt_idx_o   (rr_idx),
    .gnt_valid_o (rr_valid)
  );

  // An out-of-range sel matches no channel, so it simply yields no grant.
  always_comb begin
    fix_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i)) begin
        fix_valid = in_valid[i];
      end
    end
  end

  always_comb begin
    gnt_idx   = (mode == MODE_RR) ? rr_idx : sel;
    gnt_valid = (mode == MODE_RR) ? rr_valid : fix_valid;
    can_load  = !valid_q || out_ready;
    gnt_data  = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = !rst && can_load && gnt_valid && (gnt_idx == SW'(i));
      if (gnt_idx == SW'(i)) begin
        gnt_data = in_data[i*W +: W];
      end
    end
    xfer = |in_ready;
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (can_load) begin
      valid_d = xfer;
    end
    if (xfer) begin
      data_d = gnt_data;
      ch_d   = gnt_idx;
      if (mode == MODE_RR) begin
        ptr_d = (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule
